// File: rtl/pg_monitor.sv
// Power-good supervisor: synchronises and debounces regulator power-good pins,
// sequences a qualified system enable and latches the first failing rail.
`timescale 1ns/1ps
module pg_monitor #(
  parameter int NUM_RAILS       = 8,
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int STARTUP_CYCLES  = 6400,
  localparam int FRW = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_RAILS-1:0] pg_raw,
  input  logic [NUM_RAILS-1:0] rail_mask,
  input  logic                 fault_clear,
  output logic [NUM_RAILS-1:0] pg_filtered,
  output logic                 sys_enable,
  output logic                 fault,
  output logic [FRW-1:0]       fault_rail,
  output logic [1:0]           state
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SU_LAST = SCW'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'b00,
    ST_STARTUP = 2'b01,
    ST_RUN     = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  logic [NUM_RAILS-1:0] sync1_q, pg_sync_q;
  logic [NUM_RAILS-1:0] pg_filt_q, pg_filt_d;
  logic [DCW-1:0]       db_cnt_q [NUM_RAILS];
  logic [DCW-1:0]       db_cnt_d [NUM_RAILS];
  state_t               state_q, state_d;
  logic [SCW-1:0]       su_cnt_q, su_cnt_d;
  logic                 en_q, en_d;
  logic                 fault_q, fault_d;
  logic [FRW-1:0]       rail_q, rail_d, low_idx;
  logic [NUM_RAILS-1:0] bad;
  logic                 all_good, drop;

  // Per-rail debounce: a filtered bit flips only after DEBOUNCE_CYCLES mismatched cycles.
  always_comb begin
    pg_filt_d = pg_filt_q;
    db_cnt_d  = db_cnt_q;
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (pg_sync_q[i] == pg_filt_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]  = '0;
        pg_filt_d[i] = ~pg_filt_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DCW'(1);
      end
    end
  end

  assign bad      = ~pg_filt_q & rail_mask;
  assign drop     = |bad;
  assign all_good = &(pg_filt_q | ~rail_mask);

  // Lowest-index failing required rail; scanning downward lets the lowest one win.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      low_idx = bad[i] ? FRW'(i) : low_idx;
    end
  end

  // Sequencing FSM next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    su_cnt_d = su_cnt_q;
    en_d     = 1'b0;
    fault_d  = fault_q;
    rail_d   = rail_q;
    case (state_q)
      ST_WAIT: begin
        if (all_good) begin
          state_d  = ST_STARTUP;
          su_cnt_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STARTUP: begin
        if (drop) begin
          state_d = ST_WAIT;
        end else if (su_cnt_q == SU_LAST) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end else begin
          su_cnt_d = su_cnt_q + SCW'(1);
        end
      end
      ST_RUN: begin
        if (drop) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          rail_d  = low_idx;
        end else begin
          en_d = 1'b1;
        end
      end
      ST_FAULT: begin
        // Clearing always goes back through a full startup delay.
        if (fault_clear) begin
          state_d = ST_WAIT;
          fault_d = 1'b0;
        end else begin
          fault_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        fault_d = 1'b0;
      end
    endcase
  end

  // Synchroniser and debounce state.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      pg_sync_q <= '0;
      pg_filt_q <= '0;
      for (int i = 0; i < NUM_RAILS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= pg_raw;
      pg_sync_q <= sync1_q;
      pg_filt_q <= pg_filt_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // FSM state and its registered outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT;
      su_cnt_q <= '0;
      en_q     <= 1'b0;
      fault_q  <= 1'b0;
      rail_q   <= '0;
    end else begin
      state_q  <= state_d;
      su_cnt_q <= su_cnt_d;
      en_q     <= en_d;
      fault_q  <= fault_d;
      rail_q   <= rail_d;
    end
  end

  assign pg_filtered = pg_filt_q;
  assign sys_enable  = en_q;
  assign fault       = fault_q;
  assign fault_rail  = rail_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pg_monitor.sv
// Scoreboard bench for pg_monitor: expected output snapshots are queued with
// their due cycle when stimulus is applied and compared as the cycles elapse.
`timescale 1ns/1ps
module tb_pg_monitor;

  localparam logic [1:0] S_WAIT = 2'b00, S_SU = 2'b01, S_RUN = 2'b10, S_FLT = 2'b11;
  localparam logic [9:0] M_ALL = 10'h3FF, M_ST = 10'h300, M_EN = 10'h080, M_PF = 10'h00F;

  logic       sysclk = 1'b0;
  logic       reset, fault_clear, sys_enable, fault;
  logic [3:0] pg_raw, rail_mask, pg_filtered;
  logic [1:0] fault_rail, state;

  typedef struct {
    int         cyc;
    logic [9:0] m;
    logic [9:0] e;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int   passed = 0;
  int   total  = 0;

  pg_monitor #(.NUM_RAILS(4), .DEBOUNCE_CYCLES(4), .STARTUP_CYCLES(10)) dut (
    .sysclk(sysclk), .reset(reset), .pg_raw(pg_raw), .rail_mask(rail_mask),
    .fault_clear(fault_clear), .pg_filtered(pg_filtered), .sys_enable(sys_enable),
    .fault(fault), .fault_rail(fault_rail), .state(state)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [9:0] obs_vec();
    return {state, sys_enable, fault, fault_rail, pg_filtered};
  endfunction

  function automatic logic [9:0] mk(logic [1:0] s, logic en, logic f, logic [1:0] r, logic [3:0] pf);
    return {s, en, f, r, pf};
  endfunction

  function automatic void push(int c, logic [9:0] m, logic [9:0] e, string nm);
    sbq.push_back('{c, m, e, nm});
  endfunction

  task automatic test_reset();
    reset = 1'b1; pg_raw = 4'h0; rail_mask = 4'hF; fault_clear = 1'b0;
    #1;
    total++;
    if (obs_vec() !== 10'h000) $display("FAIL reset_initial: got %h expected 000", obs_vec());
    else passed++;
    repeat (2) @(negedge sysclk);
    total++;
    if (obs_vec() !== 10'h000) $display("FAIL reset_held: got %h expected 000", obs_vec());
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_powerup();
    pg_raw = 4'hF;
    push(5,  M_PF,        mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'h0), "pu_pf_pre");
    push(6,  M_PF | M_ST, mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'hF), "pu_pf");
    push(7,  M_ST,        mk(S_SU,   1'b0, 1'b0, 2'd0, 4'hF), "pu_startup");
    push(16, M_EN | M_ST, mk(S_SU,   1'b0, 1'b0, 2'd0, 4'hF), "pu_en_pre");
    push(17, M_ALL,       mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'hF), "pu_run");
    for (int k = 1; k <= 17; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
    end
  endtask

  task automatic test_glitch();
    pg_raw = 4'b1011;
    for (int k = 1; k <= 12; k++) push(k, M_ALL, mk(S_RUN, 1'b1, 1'b0, 2'd0, 4'hF), "glitch_hold");
    for (int k = 1; k <= 12; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
      if (k == 3) pg_raw = 4'hF;
      if (k == 5) fault_clear = 1'b1;
      if (k == 6) fault_clear = 1'b0;
    end
  endtask

  task automatic test_fault();
    pg_raw = 4'b0101;
    push(6,  M_ST | M_EN | M_PF, mk(S_RUN, 1'b1, 1'b0, 2'd0, 4'b0101), "flt_pre");
    push(7,  M_ALL, mk(S_FLT,  1'b0, 1'b1, 2'd1, 4'b0101), "flt_latch");
    push(15, M_ALL, mk(S_FLT,  1'b0, 1'b1, 2'd1, 4'hF),    "flt_hold");
    push(18, M_ALL, mk(S_FLT,  1'b0, 1'b1, 2'd1, 4'hF),    "flt_hold2");
    push(19, M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd1, 4'hF),    "flt_clear");
    push(20, M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd1, 4'hF),    "flt_restart");
    push(29, M_EN | M_ST, mk(S_SU, 1'b0, 1'b0, 2'd1, 4'hF), "flt_en_pre");
    push(30, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd1, 4'hF),    "flt_run");
    for (int k = 1; k <= 30; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
      if (k == 6)  fault_clear = 1'b1;
      if (k == 7)  fault_clear = 1'b0;
      if (k == 9)  pg_raw = 4'hF;
      if (k == 18) fault_clear = 1'b1;
      if (k == 19) fault_clear = 1'b0;
    end
  endtask

  task automatic test_clear_while_bad();
    pg_raw = 4'b1011;
    push(7,  M_ALL, mk(S_FLT,  1'b0, 1'b1, 2'd2, 4'b1011), "cwb_latch");
    push(9,  M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd2, 4'b1011), "cwb_wait");
    push(14, M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd2, 4'b1011), "cwb_stay");
    push(20, M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd2, 4'hF),    "cwb_pf");
    push(21, M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd2, 4'hF),    "cwb_startup");
    push(30, M_EN | M_ST, mk(S_SU, 1'b0, 1'b0, 2'd2, 4'hF), "cwb_en_pre");
    push(31, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd2, 4'hF),    "cwb_run");
    for (int k = 1; k <= 31; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
      if (k == 8)  fault_clear = 1'b1;
      if (k == 9)  fault_clear = 1'b0;
      if (k == 14) pg_raw = 4'hF;
    end
  endtask

  task automatic test_startup_abort();
    reset = 1'b1; pg_raw = 4'h0;
    @(negedge sysclk);
    reset = 1'b0; pg_raw = 4'hF;
    push(7,  M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd0, 4'hF),    "abort_startup");
    push(15, M_ALL, mk(S_SU,   1'b0, 1'b0, 2'd0, 4'b1110), "abort_pf");
    push(16, M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'b1110), "abort_wait");
    push(17, M_ALL, mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'b1110), "abort_no_run");
    push(22, M_ST | M_PF, mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'hF), "abort_pf_back");
    push(23, M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd0, 4'hF),    "abort_reentry");
    push(32, M_EN | M_ST, mk(S_SU, 1'b0, 1'b0, 2'd0, 4'hF), "abort_en_pre");
    push(33, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'hF),    "abort_run");
    for (int k = 1; k <= 33; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
      if (k == 9)  pg_raw = 4'b1110;
      if (k == 16) pg_raw = 4'hF;
    end
  endtask

  task automatic test_mask();
    reset = 1'b1; pg_raw = 4'h0; rail_mask = 4'b0111;
    @(negedge sysclk);
    reset = 1'b0; pg_raw = 4'b0111;
    push(6,  M_PF,  mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'b0111), "mask_pf");
    push(7,  M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd0, 4'b0111), "mask_startup");
    push(16, M_EN,  mk(S_SU,   1'b0, 1'b0, 2'd0, 4'b0111), "mask_en_pre");
    push(17, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'b0111), "mask_run");
    push(24, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'hF),    "mask_r3_up");
    push(32, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'b0111), "mask_r3_down");
    push(35, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'b0111), "mask_no_fault");
    for (int k = 1; k <= 35; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      while (sbq.size() > 0 && sbq[0].cyc == k) begin
        ex = sbq.pop_front(); total++;
        if ((obs_vec() & ex.m) !== (ex.e & ex.m))
          $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
        else passed++;
      end
      if (k == 18) pg_raw = 4'hF;
      if (k == 26) pg_raw = 4'b0111;
    end
    rail_mask = 4'hF;
  endtask

  task automatic test_async_reset();
    for (int phase = 0; phase < 2; phase++) begin
      reset = 1'b1; pg_raw = 4'h0;
      @(negedge sysclk);
      reset = 1'b0; pg_raw = 4'hF;
      push(7,  M_ST, mk(S_SU, 1'b0, 1'b0, 2'd0, 4'hF), "ar_startup");
      push(10, M_ST, mk(S_SU, 1'b0, 1'b0, 2'd0, 4'hF), "ar_startup_mid");
      push(17, M_ALL, mk(S_RUN, 1'b1, 1'b0, 2'd0, 4'hF), "ar_run");
      if (phase == 1) push(24, M_ALL, mk(S_FLT, 1'b0, 1'b1, 2'd3, 4'b0111), "ar_fault");
      for (int k = 1; k <= ((phase == 0) ? 10 : 26); k++) begin
        @(posedge sysclk); @(negedge sysclk);
        while (sbq.size() > 0 && sbq[0].cyc == k) begin
          ex = sbq.pop_front(); total++;
          if ((obs_vec() & ex.m) !== (ex.e & ex.m))
            $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
          else passed++;
        end
        if (k == 17) pg_raw = 4'b0111;
      end
      if (phase == 0) sbq.delete();
      #2 reset = 1'b1;
      #1;
      total++;
      if (obs_vec() !== 10'h000) $display("FAIL async_reset_phase%0d: got %h expected 000", phase, obs_vec());
      else passed++;
      pg_raw = 4'hF;
      @(negedge sysclk);
      reset = 1'b0;
      push(5,  M_PF,  mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'h0), "ar_pu_pf_pre");
      push(6,  M_PF | M_ST, mk(S_WAIT, 1'b0, 1'b0, 2'd0, 4'hF), "ar_pu_pf");
      push(7,  M_ST,  mk(S_SU,   1'b0, 1'b0, 2'd0, 4'hF), "ar_pu_startup");
      push(16, M_EN | M_ST, mk(S_SU, 1'b0, 1'b0, 2'd0, 4'hF), "ar_pu_en_pre");
      push(17, M_ALL, mk(S_RUN,  1'b1, 1'b0, 2'd0, 4'hF), "ar_pu_run");
      for (int k = 1; k <= 17; k++) begin
        @(posedge sysclk); @(negedge sysclk);
        while (sbq.size() > 0 && sbq[0].cyc == k) begin
          ex = sbq.pop_front(); total++;
          if ((obs_vec() & ex.m) !== (ex.e & ex.m))
            $display("FAIL %s cycle %0d: got %h expected %h", ex.nm, k, obs_vec() & ex.m, ex.e & ex.m);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_glitch();
    test_fault();
    test_clear_while_bad();
    test_startup_abort();
    test_mask();
    test_async_reset();
    total++;
    if (sbq.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pg_monitor.md
# pg_monitor

Power-good supervisor that sits directly upstream of the DSP power sequencer and the board-level enable logic on the CPLD. It synchronises and debounces the raw regulator power-good pins and produces a qualified `sys_enable` only after every required rail has been stably good for a startup delay. A required rail that drops while running latches a fault, drops `sys_enable`, and records the offending rail. It is clocked from the internal UFM oscillator (3.3–5.5 MHz).

## Interface

**Parameters**
- `NUM_RAILS`, default 8: number of power-good inputs; minimum 1.
- `DEBOUNCE_CYCLES`, default 64: consecutive stable cycles needed to change a filtered bit; minimum 1.
- `STARTUP_CYCLES`, default 6400: hold time from all-good to enable, ≈1.6 ms at 4 MHz; minimum 1.

**Ports**
- `sysclk`  in  1  oscillator clock; every flop is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pg_raw`  in  NUM_RAILS  raw power-good pins; asynchronous to `sysclk`.
- `rail_mask`  in  NUM_RAILS  1 = rail is required for enable and fault detection; treated as quasi-static.
- `fault_clear`  in  1  synchronous pulse that leaves FAULT.
- `pg_filtered`  out  NUM_RAILS  debounced power-good, registered.
- `sys_enable`  out  1  qualified system enable, registered.
- `fault`  out  1  latched fault flag, registered.
- `fault_rail`  out  $clog2(NUM_RAILS), minimum 1  index of the rail that caused the fault.
- `state`  out  2  current FSM state, for LEDs and debug.

## Operation

**Reset**
- `reset` asserted forces: `pg_filtered`=0, all counters=0, synchroniser flops=0, `state`=WAIT (2'b00), `sys_enable`=0, `fault`=0, `fault_rail`=0.
- Reset may arrive in any state and takes effect immediately.

**Input path, per rail**
- Two-flop synchroniser: `pg_raw[i]` → `pg_sync[i]`.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
  - If `pg_sync[i]` == `pg_filtered[i]`, the counter clears to 0.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, `pg_filtered[i]` toggles on the next edge and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
- Counters never wrap.

**Combinational qualifiers**
- `all_good` = &(`pg_filtered` | ~`rail_mask`).
- `drop` = |(~`pg_filtered` & `rail_mask`).
- `rail_mask`=0 makes `all_good`=1 and `drop`=0.

**FSM**
- WAIT (00): `sys_enable`=0. Goes to STARTUP when `all_good`; the startup counter is cleared on entry.
- STARTUP (01): `sys_enable`=0. The counter increments each cycle.
  - If `drop`, go to WAIT. This is not a fault.
  - Otherwise, when the counter reaches STARTUP_CYCLES-1, go to RUN.
- RUN (10): `sys_enable`=1. If `drop`:
  - go to FAULT;
  - set `fault`=1;
  - set `fault_rail` = lowest index i with `rail_mask[i]` & ~`pg_filtered[i]`.
- FAULT (11): `sys_enable`=0 and `fault`=1 are held. `fault_clear` goes to WAIT and clears `fault`; `fault_rail` keeps its last value.

**Boundary rules**
- `fault_clear` outside FAULT is ignored.
- `drop` and `fault_clear` in the same RUN cycle: go to FAULT; the drop wins.
- `fault_clear` while rails are still bad: go to WAIT, then stay in WAIT until `all_good`.
- Leaving FAULT always repeats the full startup delay. There is no fast restart.
- Multiple rails dropping in the same cycle: `fault_rail` reports the lowest index.

## Timing

- Raw edge to `pg_filtered` change: 2 + DEBOUNCE_CYCLES cycles.
- `pg_filtered` all-good to STARTUP: 1 cycle.
- STARTUP to RUN: STARTUP_CYCLES cycles.
- Total from the last required `pg_raw` rise to `sys_enable`=1: 3 + DEBOUNCE_CYCLES + STARTUP_CYCLES cycles.
- `pg_filtered` fall to `sys_enable`=0, with `fault`=1 and `fault_rail` valid on the same edge: 1 cycle.
- Total from a `pg_raw` fall to `sys_enable`=0: 3 + DEBOUNCE_CYCLES cycles.
- `fault_clear` to `state`=WAIT and `fault`=0: 1 cycle.
- All outputs are glitch-free registered signals.

## Test plan

Bench parameters: NUM_RAILS=4, DEBOUNCE_CYCLES=4, STARTUP_CYCLES=10.

- **Power-up:** `rail_mask`=4'hF, `pg_raw` 0→4'hF at cycle 0 → `pg_filtered`=4'hF at cycle 6, `state`=01 at cycle 7, `sys_enable`=1 at cycle 17; `fault` stays 0.
- **Glitch reject:** in RUN, `pg_raw[2]` low for 3 cycles → `pg_filtered`, `sys_enable` and `state` unchanged.
- **Fault:**
  - In RUN, `pg_raw[1]` and `pg_raw[3]` fall together at cycle t → `sys_enable`=0, `fault`=1, `fault_rail`=1, `state`=11 at t+7.
  - `fault_clear` with rails restored → `state`=00, `fault`=0, then `sys_enable`=1 only after a further 11 cycles.
- **Startup abort:** rail 0 drops and is debounced during STARTUP → `state`=00, `fault`=0, and the startup counter restarts from 0 on re-entry.
- **Mask:** `rail_mask`=4'b0111, `pg_raw[3]` held 0 → `sys_enable`=1 at cycle 17; toggling `pg_raw[3]` in RUN causes no fault.
- **Async reset:** assert `reset` mid-STARTUP and mid-FAULT, between clock edges → all outputs 0 immediately, without waiting for a clock edge; after release, power-up timing is identical to the first scenario.
